// File: rtl/apb3_master_mux.sv
// apb3_master_mux: valid/ready command port to multi-slave APB3 bridge master.
// Decodes slave from address, honours wait states/PSLVERR, aborts on timeout.
`default_nettype none

module apb3_master_mux #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int NUM_SLAVES    = 4,
  parameter int SLV_SPAN_LOG2 = 8,
  parameter int TIMEOUT       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                derr_late;

  logic [ADDR_W-1:0]   req_idx_full;
  logic                decode_err;
  logic                accept;
  logic                done;
  logic                timeout_hit;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  assign req_idx_full = req_addr >> SLV_SPAN_LOG2;
  assign decode_err   = (req_idx_full >= ADDR_W'(NUM_SLAVES));

  // Only the addressed slave's handshake inputs are ever observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = pready[k];
        sel_err   = pslverr[k];
        sel_rdata = prdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign done        = (state == ACCESS) && sel_ready;
  assign timeout_hit = (state == ACCESS) && !sel_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign req_ready   = (state == IDLE) || done;
  assign accept      = req_valid && req_ready;

  always_comb begin
    psel = '0;
    if (state == SETUP || state == ACCESS) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        psel[k] = (idx_q == IDX_W'(k));
      end
    end
  end

  assign penable = (state == ACCESS);
  assign pwrite  = write_q;
  assign paddr   = addr_q;
  assign pwdata  = write_q ? wdata_q : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = decode_err ? DERR : SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          if (accept) state_nxt = decode_err ? DERR : SETUP;
          else        state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      DERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wait_cnt  <= '0;
      derr_late <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;
      derr_late <= accept && decode_err && (state == ACCESS);

      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        write_q  <= req_write;
        idx_q    <= req_idx_full[IDX_W-1:0];
        wait_cnt <= '0;
      end else if (state == ACCESS && !sel_ready && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      // A decode error accepted on a completing ACCESS cycle would collide with
      // that transfer's response, so its pulse is deferred until after DERR.
      if (done || timeout_hit) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (done && !write_q && !sel_err) ? sel_rdata : '0;
        rsp_err   <= timeout_hit || sel_err;
      end else if (accept && decode_err) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else if (state == DERR && derr_late) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb3_master_mux.sv
// tb_apb3_master_mux: directed self-checking bench for apb3_master_mux.
`default_nettype none

module tb_apb3_master_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [NS-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]   pready;
  logic [NS-1:0]   pslverr;

  int checks   = 0;
  int failures = 0;

  apb3_master_mux #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SLV_SPAN_LOG2(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = '1;
    pslverr   = '0;
    prdata    = {32'h3333_0003, 32'h1234_5678, 32'h1111_0001, 32'h0000_0A0A};
    #2;
    chk("rst_psel",    psel, 4'b0000);
    chk("rst_penable", penable, 0);
    chk("rst_rspv",    rsp_valid, 0);
    chk("rst_paddr",   paddr, 0);
    chk("rst_pwdata",  pwdata, 0);
    chk("rst_rsperr",  rsp_err, 0);
    step(); step();
    reset = 1'b1;
    step();

    // Zero-wait write to slave 0
    cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    #1 chk("w_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("w_setup_psel", psel, 4'b0001);
    chk("w_setup_pen",  penable, 0);
    step();
    chk("w_acc_psel",  psel, 4'b0001);
    chk("w_acc_pen",   penable, 1);
    chk("w_acc_pwd",   pwdata, 32'hDEAD_BEEF);
    chk("w_acc_pwr",   pwrite, 1);
    chk("w_acc_paddr", paddr, 32'h4);
    chk("w_acc_rspv",  rsp_valid, 0);
    step();
    chk("w_rspv",   rsp_valid, 1);
    chk("w_rsperr", rsp_err, 0);
    chk("w_rdata",  rsp_rdata, 0);
    chk("w_psel0",  psel, 4'b0000);
    step();
    chk("w_rspv_pulse", rsp_valid, 0);

    // Read from slave 2 with three wait states
    pready[2] = 1'b0;
    cmd(1'b0, 32'h0000_0210, 32'hFFFF_FFFF);
    step();
    req_valid = 1'b0;
    chk("r_setup_psel", psel, 4'b0100);
    chk("r_pwdata_rd",  pwdata, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("r_wait_pen",   penable, 1);
      chk("r_wait_ready", req_ready, 0);
      step();
    end
    chk("r_acc4_pen", penable, 1);
    pready[2] = 1'b1;
    #1 chk("r_acc4_ready", req_ready, 1);
    step();
    chk("r_rspv",   rsp_valid, 1);
    chk("r_rdata",  rsp_rdata, 32'h1234_5678);
    chk("r_rsperr", rsp_err, 0);

    // Decode error: idx 5
    step();
    cmd(1'b0, 32'h0000_0500, 32'h0);
    step();
    req_valid = 1'b0;
    chk("d_psel",   psel, 4'b0000);
    chk("d_pen",    penable, 0);
    chk("d_rspv",   rsp_valid, 1);
    chk("d_rsperr", rsp_err, 1);
    chk("d_rdata",  rsp_rdata, 0);
    step();
    chk("d_rspv_pulse", rsp_valid, 0);
    chk("d_ready_idle", req_ready, 1);

    // Timeout on slave 1
    pready[1] = 1'b0;
    cmd(1'b0, 32'h0000_0100, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("t_acc_psel", psel, 4'b0010);
      chk("t_acc_rspv", rsp_valid, 0);
      step();
    end
    chk("t_rspv",   rsp_valid, 1);
    chk("t_rsperr", rsp_err, 1);
    chk("t_rdata",  rsp_rdata, 0);
    chk("t_psel0",  psel, 4'b0000);
    chk("t_pen0",   penable, 0);
    chk("t_ready",  req_ready, 1);
    pready[1] = 1'b1;

    // Back-to-back: write slave 0, read slave 1, write slave 3 with error
    pslverr[3] = 1'b1;
    cmd(1'b1, 32'h0000_0004, 32'hAAAA_5555);
    step();
    cmd(1'b0, 32'h0000_0104, 32'h0);
    chk("b_setup1_psel",  psel, 4'b0001);
    chk("b_setup1_ready", req_ready, 0);
    step();
    chk("b_acc1_ready", req_ready, 1);
    step();
    cmd(1'b1, 32'h0000_0304, 32'h5A5A_5A5A);
    chk("b_setup2_psel", psel, 4'b0010);
    chk("b_setup2_pen",  penable, 0);
    chk("b_rsp1_v",      rsp_valid, 1);
    chk("b_rsp1_err",    rsp_err, 0);
    step();
    chk("b_acc2_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("b_setup3_psel", psel, 4'b1000);
    chk("b_rsp2_v",      rsp_valid, 1);
    chk("b_rsp2_rdata",  rsp_rdata, 32'h1111_0001);
    step();
    chk("b_acc3_pwdata", pwdata, 32'h5A5A_5A5A);
    step();
    chk("b_rsp3_v",   rsp_valid, 1);
    chk("b_rsp3_err", rsp_err, 1);
    pslverr[3] = 1'b0;
    step();

    // Reset asserted mid-ACCESS
    pready[2] = 1'b0;
    cmd(1'b0, 32'h0000_0200, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    chk("x_acc_pen", penable, 1);
    #2 reset = 1'b0;
    #1;
    chk("x_psel0", psel, 4'b0000);
    chk("x_pen0",  penable, 0);
    chk("x_rspv0", rsp_valid, 0);
    step();
    pready[2] = 1'b1;
    #2 reset = 1'b1;
    step();
    chk("x_norsp", rsp_valid, 0);
    chk("x_ready", req_ready, 1);
    cmd(1'b0, 32'h0000_0208, 32'h0);
    step();
    req_valid = 1'b0;
    chk("x_setup_psel", psel, 4'b0100);
    chk("x_setup_pen",  penable, 0);
    step();
    step();
    chk("x_rspv",  rsp_valid, 1);
    chk("x_rdata", rsp_rdata, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb3_master_mux.md
Name: apb3_master_mux

Overview:
- Parametrised APB3 bridge master: accepts single read/write commands on a valid/ready request port and drives an APB3 bus with NUM_SLAVES select lines.
- Decodes the target slave from address bits; honours per-slave PREADY wait states and PSLVERR; aborts stalled transfers by timeout.
- Returns one response (data plus error) per command.
- Sits between a command source (CPU/testbench/DMA) and the peripheral slave bank; supersedes the fixed two-slave, always-ready master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SLAVES, 4, number of slaves/psel lines (1..16).
- SLV_SPAN_LOG2, 8, log2 bytes per slave window (slave k owns [k<<SLV_SPAN_LOG2, (k+1)<<SLV_SPAN_LOG2)).
- TIMEOUT, 16, max ACCESS cycles with pready low before abort (>=1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&ready at clk edge
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  1=slave error, decode error or timeout
- psel  out  NUM_SLAVES  one-hot slave select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  NUM_SLAVES*DATA_W  per-slave read data, slave k at bits [k*DATA_W +: DATA_W]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (reset=0, async): state IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Any transfer in flight is dropped with no response.
- Decode on accept: idx = req_addr >> SLV_SPAN_LOG2. Decode error if idx >= NUM_SLAVES. Address, write flag, wdata and idx are registered at acceptance and held stable through SETUP and ACCESS.
- States: IDLE, SETUP, ACCESS, DERR.
- req_ready = (state==IDLE) | (state==ACCESS & pready[idx]). Combinational; no other state accepts.
- IDLE: on accept, go to SETUP (valid decode) or DERR (decode error). Otherwise stay in IDLE.
- SETUP: psel[idx]=1, penable=0; always go to ACCESS next cycle.
- ACCESS: psel[idx]=1, penable=1; the wait counter increments each cycle pready[idx]=0.
  - If pready[idx]=1: the transfer completes. Capture rsp_rdata = prdata[idx] (reads; 0 for writes) and rsp_err = pslverr[idx]. If a new command is accepted in the same cycle, go directly to SETUP/DERR (back-to-back, no IDLE bubble); otherwise go to IDLE.
  - Timeout: if pready[idx]=0 and the counter reaches TIMEOUT, go to IDLE with rsp_err=1 and rsp_rdata=0. psel and penable drop the next cycle.
- DERR: no psel asserted, no APB activity; rsp_valid=1, rsp_err=1, rsp_rdata=0 for exactly one cycle, then IDLE.
- Response timing: rsp_valid is a registered pulse asserted the cycle after the completing ACCESS cycle (or during DERR). Zero-wait transfer: accept at edge T, SETUP in cycle T+1, ACCESS in T+2, rsp_valid in T+3. rsp_rdata/rsp_err hold until the next response.
- psel is one-hot or all-zero at all times; penable=1 only together with a psel bit. pwdata is driven with the held wdata for writes and 0 for reads.
- Only pready/pslverr/prdata of the selected slave are observed; other slaves' inputs are ignored.
- The wait counter clears on entry to SETUP.
- req_* changes while req_ready=0 have no effect.

Test Plan:
- Write 0x0000_0004 data 0xDEADBEEF, slave 0 pready=1 -> psel=4'b0001 in SETUP, penable in ACCESS, pwdata=0xDEADBEEF; rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
- Read 0x0000_0210, slave 2 prdata=0x1234_5678 with pready low for 3 ACCESS cycles -> psel=4'b0100, ACCESS lasts 4 cycles, rsp_rdata=0x1234_5678, rsp_err=0.
- Read 0x0000_0500 (idx 5 >= 4) -> psel stays 0, DERR, rsp_valid one cycle with rsp_err=1, rsp_rdata=0.
- Slave 1 holds pready=0 forever -> after TIMEOUT=16 ACCESS cycles, rsp_err=1, psel/penable return to 0, next command accepted.
- Back-to-back: write 0x004, then read 0x104 with req_valid held, slave 3 pslverr=1 on a third access -> no IDLE cycle between transfers; third response rsp_err=1.
- Assert reset low mid-ACCESS -> psel, penable and rsp_valid go 0 immediately; no response; first command after release starts from IDLE.
